// File: rtl/godai_trace_collector.sv
`default_nettype none
// ============================================================================
// Module   : godai_trace_collector
// Purpose  : Snoops Godai instruction fetches and tracing strobes, forms
//            timestamped trace records and buffers them behind a valid/ready port.
// Revision : 1.0 - initial release
// ============================================================================
module godai_trace_collector #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int TS_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  instr_req_i,
    input  logic                  instr_gnt_i,
    input  logic                  instr_rvalid_i,
    input  logic [ADDR_WIDTH-1:0] instr_addr_i,
    input  logic [DATA_WIDTH-1:0] instr_rdata_i,
    input  logic                  jump_done_i,
    input  logic                  branch_decision_i,
    input  logic                  branch_req_i,
    input  logic                  pc_set_i,
    input  logic                  is_decoding_i,
    input  logic                  clear_i,
    output logic                  trace_valid_o,
    input  logic                  trace_ready_i,
    output logic [ADDR_WIDTH-1:0] trace_addr_o,
    output logic [DATA_WIDTH-1:0] trace_instr_o,
    output logic [3:0]            trace_flags_o,
    output logic [TS_WIDTH-1:0]   trace_ts_o,
    output logic                  overflow_o,
    output logic                  proto_err_o,
    output logic [7:0]            drop_count_o
);

    localparam int c_ptr_w = $clog2(FIFO_DEPTH);
    localparam int c_rec_w = ADDR_WIDTH + DATA_WIDTH + 4 + TS_WIDTH;

    logic [TS_WIDTH-1:0]   r_ts;
    logic [ADDR_WIDTH-1:0] r_q_addr [2];
    logic [1:0]            r_q_cnt;
    logic                  r_acc_taken;
    logic                  r_acc_jump;
    logic                  r_acc_pcset;
    logic                  r_gap;
    logic [c_rec_w-1:0]    r_mem [FIFO_DEPTH];
    logic [c_ptr_w:0]      r_wr_ptr;
    logic [c_ptr_w:0]      r_rd_ptr;
    logic                  r_overflow;
    logic                  r_proto_err;
    logic [7:0]            r_drop_cnt;

    logic                  w_pop;
    logic                  w_push;
    logic [1:0]            w_cnt_mid;
    logic                  w_push_ok;
    logic                  w_proto_ev;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_rd;
    logic                  w_wr;
    logic                  w_drop;
    logic [3:0]            w_flags;
    logic [c_rec_w-1:0]    w_rec;
    logic [c_rec_w-1:0]    w_head;
    logic                  w_unused;

    // Reserved strobe: accepted on the port but has no effect on records.
    assign w_unused   = is_decoding_i;

    // A pop frees its slot before the same-cycle push claims one.
    assign w_pop      = instr_rvalid_i && (r_q_cnt != 2'd0);
    assign w_push     = instr_req_i && instr_gnt_i;
    assign w_cnt_mid  = r_q_cnt - {1'b0, w_pop};
    assign w_push_ok  = w_push && (w_cnt_mid != 2'd2);
    assign w_proto_ev = (instr_rvalid_i && (r_q_cnt == 2'd0)) || (w_push && !w_push_ok);

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_ptr_w] != r_rd_ptr[c_ptr_w]) &&
                     (r_wr_ptr[c_ptr_w-1:0] == r_rd_ptr[c_ptr_w-1:0]);
    assign w_rd    = !w_empty && trace_ready_i;
    assign w_wr    = w_pop && (!w_full || w_rd);
    assign w_drop  = w_pop && !w_wr;

    assign w_flags = {r_gap,
                      r_acc_pcset | pc_set_i,
                      r_acc_jump  | jump_done_i,
                      r_acc_taken | (branch_req_i && branch_decision_i)};
    assign w_rec   = {r_q_addr[0], instr_rdata_i, w_flags, r_ts};
    assign w_head  = r_mem[r_rd_ptr[c_ptr_w-1:0]];

    assign trace_valid_o = !w_empty;
    assign trace_addr_o  = w_head[c_rec_w-1 -: ADDR_WIDTH];
    assign trace_instr_o = w_head[TS_WIDTH+4 +: DATA_WIDTH];
    assign trace_flags_o = w_head[TS_WIDTH +: 4];
    assign trace_ts_o    = w_head[TS_WIDTH-1:0];
    assign overflow_o    = r_overflow;
    assign proto_err_o   = r_proto_err;
    assign drop_count_o  = r_drop_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ts        <= '0;
            r_q_addr[0] <= '0;
            r_q_addr[1] <= '0;
            r_q_cnt     <= 2'd0;
            r_acc_taken <= 1'b0;
            r_acc_jump  <= 1'b0;
            r_acc_pcset <= 1'b0;
            r_gap       <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_overflow  <= 1'b0;
            r_proto_err <= 1'b0;
            r_drop_cnt  <= 8'd0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_ts <= r_ts + 1'b1;

            if (w_pop) begin
                r_q_addr[0] <= r_q_addr[1];
            end
            if (w_push_ok) begin
                r_q_addr[w_cnt_mid[0]] <= instr_addr_i;
            end
            r_q_cnt <= w_cnt_mid + {1'b0, w_push_ok};

            // Strobes are folded into the record being formed this cycle.
            if (w_pop) begin
                r_acc_taken <= 1'b0;
                r_acc_jump  <= 1'b0;
                r_acc_pcset <= 1'b0;
            end else begin
                r_acc_taken <= r_acc_taken | (branch_req_i && branch_decision_i);
                r_acc_jump  <= r_acc_jump  | jump_done_i;
                r_acc_pcset <= r_acc_pcset | pc_set_i;
            end

            if (w_wr) begin
                r_mem[r_wr_ptr[c_ptr_w-1:0]] <= w_rec;
                r_wr_ptr <= r_wr_ptr + 1'b1;
                r_gap    <= 1'b0;
            end else if (w_drop) begin
                r_gap    <= 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end

            // A new event in the clear cycle takes precedence over the clear.
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (clear_i) begin
                    r_drop_cnt <= 8'd1;
                end else if (r_drop_cnt != 8'hFF) begin
                    r_drop_cnt <= r_drop_cnt + 8'd1;
                end
            end else if (clear_i) begin
                r_overflow <= 1'b0;
                r_drop_cnt <= 8'd0;
            end

            if (w_proto_ev) begin
                r_proto_err <= 1'b1;
            end else if (clear_i) begin
                r_proto_err <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
